dmem_port_ctrl: RTL

Per-core request controller that sits directly upstream of one port of the shared 16-port `data_memory`. It accepts load/store requests from a core over a valid/ready handshake and buffers them in order. It drives the port's `Control`/`DataAddr`/`DataIn` lines with registered outputs, then captures `DataOut` on the correct cycle and returns read data over a second valid/ready handshake. One instance exists per core, instance k wired to port k.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/dmem_port_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared constants and entry types for the data_memory port controller.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] MEM_IDLE    = 2'd0;
    localparam logic [1:0] MEM_RD_IRAM = 2'd1;
    localparam logic [1:0] MEM_RD      = 2'd2;
    localparam logic [1:0] MEM_WR      = 2'd3;
    localparam int         MEM_WORDS   = 128;

    typedef struct packed {
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Show-ahead synchronous FIFO; pushes while full are refused outright.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_wdata,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [AW-1:0]   c_last  = AW'(DEPTH - 1);
    localparam logic [CW-1:0]   c_depth = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != c_depth);
    assign w_pop   = i_pop  && (r_count != '0);
    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_count == c_depth);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_ctrl
// Purpose  : In-order load/store controller for one data_memory port, with
//            registered port drive and a 2-stage return tag for read data.
// Revision : 1.0
// ============================================================================
module dmem_port_ctrl
    import dmem_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int MEM_WORDS = dmem_pkg::MEM_WORDS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        oob_seen,
    output logic [1:0]  mem_control,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam int            CW          = $clog2(RSP_DEPTH + 1);
    localparam int            QW          = $clog2(REQ_DEPTH + 1);
    localparam logic [16:0]   c_words     = 17'(MEM_WORDS);
    localparam logic [CW-1:0] c_rsp_depth = CW'(RSP_DEPTH);

    req_t          w_req_in;
    req_t          w_head;
    rsp_t          w_rsp_in;
    rsp_t          w_rsp_head;
    logic          w_req_full;
    logic          w_req_empty;
    logic [QW-1:0] w_req_count;
    logic          w_rsp_full;
    logic          w_rsp_empty;
    logic [CW-1:0] w_rsp_count;
    logic          w_req_push;
    logic          w_rsp_pop;
    logic          w_head_oob;
    logic [CW-1:0] w_rd_net;
    logic          w_issue;
    logic          w_issue_rd;

    logic [1:0]    r_mem_control;
    logic [15:0]   r_mem_addr;
    logic [15:0]   r_mem_wdata;
    logic          r_oob_seen;
    logic [1:0]    r_tag;
    logic [1:0]    r_tag_err;
    logic [CW-1:0] r_rd_out;

    assign w_req_in   = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign req_ready  = !reset && !w_req_full;
    assign w_req_push = req_valid && req_ready;

    sync_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_req_push),
        .i_wdata (w_req_in),
        .i_pop   (w_issue),
        .o_rdata (w_head),
        .o_full  (w_req_full),
        .o_empty (w_req_empty),
        .o_count (w_req_count)
    );

    // A pop this cycle frees a response slot in time for a read issued now.
    assign w_rsp_pop  = rsp_valid && rsp_ready;
    assign w_rd_net   = r_rd_out - CW'(w_rsp_pop);
    assign w_head_oob = ({1'b0, w_head.addr} >= c_words);
    assign w_issue    = !w_req_empty && (w_head.write || (w_rd_net < c_rsp_depth));
    assign w_issue_rd = w_issue && !w_head.write;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_control <= MEM_IDLE;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_oob_seen    <= 1'b0;
            r_tag         <= '0;
            r_tag_err     <= '0;
            r_rd_out      <= '0;
        end else begin
            r_mem_control <= MEM_IDLE;
            if (w_issue && !w_head_oob) begin
                r_mem_control <= w_head.write ? MEM_WR : MEM_RD;
                r_mem_addr    <= w_head.addr;
                if (w_head.write) begin
                    r_mem_wdata <= w_head.wdata;
                end
            end
            if (w_issue && w_head_oob) begin
                r_oob_seen <= 1'b1;
            end
            r_tag     <= {r_tag[0], w_issue_rd};
            r_tag_err <= {r_tag_err[0], w_issue_rd && w_head_oob};
            r_rd_out  <= r_rd_out + CW'(w_issue_rd) - CW'(w_rsp_pop);
            assert (w_rsp_count <= r_rd_out);
            assert (32'(w_req_count) <= REQ_DEPTH);
        end
    end

    // Out-of-range reads ride the same tag pipeline but never sample the port.
    assign w_rsp_in = '{data: r_tag_err[1] ? 16'h0000 : mem_rdata, err: r_tag_err[1]};

    sync_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (r_tag[1]),
        .i_wdata (w_rsp_in),
        .i_pop   (w_rsp_pop),
        .o_rdata (w_rsp_head),
        .o_full  (w_rsp_full),
        .o_empty (w_rsp_empty),
        .o_count (w_rsp_count)
    );

    assign rsp_valid   = !w_rsp_empty;
    assign rsp_data    = rsp_valid ? w_rsp_head.data : 16'h0000;
    assign rsp_err     = rsp_valid && w_rsp_head.err;
    assign oob_seen    = r_oob_seen;
    assign mem_control = r_mem_control;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(w_rsp_full && r_tag[1]));
        end
    end

endmodule
`default_nettype wire
